// File: rtl/force_cache_readout_sequencer_if.sv
// Bus between the force write-back sequencer, the force cache and the motion-update stage.
// Handshake: a force moves downstream in any cycle where out_force_valid && in_force_ready; the payload holds while valid is high and not yet accepted.
interface force_cache_readout_sequencer_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ADDR_WIDTH   = 9,
  parameter int PARTICLE_ID_WIDTH = 21
);
  logic                         in_start;
  logic [CELL_ADDR_WIDTH-1:0]   in_particle_num;
  logic                         out_read_data_request;
  logic [CELL_ADDR_WIDTH-1:0]   out_cache_read_address;
  logic [3*DATA_WIDTH-1:0]      in_partial_force;
  logic                         in_cache_readout_valid;
  logic                         out_force_valid;
  logic [PARTICLE_ID_WIDTH-1:0] out_particle_id;
  logic [3*DATA_WIDTH-1:0]      out_force;
  logic                         in_force_ready;
  logic                         out_busy;
  logic                         out_done;
  logic                         out_error;
  logic [2:0]                   dbg_state;

  modport master (
    input  in_start, in_particle_num, in_partial_force, in_cache_readout_valid, in_force_ready,
    output out_read_data_request, out_cache_read_address, out_force_valid, out_particle_id,
    output out_force, out_busy, out_done, out_error, dbg_state
  );

  modport slave (
    output in_start, in_particle_num, in_partial_force, in_cache_readout_valid, in_force_ready,
    input  out_read_data_request, out_cache_read_address, out_force_valid, out_particle_id,
    input  out_force, out_busy, out_done, out_error, dbg_state
  );
endinterface

// File: rtl/force_cache_readout_sequencer.sv
// End-of-iteration force cache readout: drain wait, credit-gated address sweep 1..N,
// ID tagging of returned forces and a first-word fall-through output FIFO.
module force_cache_readout_sequencer #(
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_X            = 2,
  parameter int CELL_Y            = 2,
  parameter int CELL_Z            = 2,
  parameter int CELL_ID_WIDTH     = 4,
  parameter int CELL_ADDR_WIDTH   = 9,
  parameter int PARTICLE_ID_WIDTH = 3*CELL_ID_WIDTH+CELL_ADDR_WIDTH,
  parameter int DRAIN_CYCLES      = 16,
  parameter int READ_LATENCY      = 3,
  parameter int OUT_FIFO_DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  force_cache_readout_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int AW      = CELL_ADDR_WIDTH;
  localparam int FW      = 3*DATA_WIDTH;
  localparam int ENTRY_W = PARTICLE_ID_WIDTH + FW;
  localparam int PTR_W   = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 2;
  localparam int DRN_W   = $clog2(DRAIN_CYCLES + 1) + 1;
  localparam int IGN_W   = $clog2(READ_LATENCY + 1) + 1;

  localparam logic [CNT_W-1:0]         DEPTH_C    = CNT_W'(OUT_FIFO_DEPTH);
  localparam logic [DRN_W-1:0]         DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRN_W-1:0]         DRAIN_ONE  = DRN_W'(1);
  localparam logic [IGN_W-1:0]         IGN_INIT   = IGN_W'(READ_LATENCY);
  localparam logic [AW-1:0]            ADDR_ONE   = AW'(1);
  localparam logic [CELL_ID_WIDTH-1:0] CX         = CELL_ID_WIDTH'(CELL_X);
  localparam logic [CELL_ID_WIDTH-1:0] CY         = CELL_ID_WIDTH'(CELL_Y);
  localparam logic [CELL_ID_WIDTH-1:0] CZ         = CELL_ID_WIDTH'(CELL_Z);

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    n_q, n_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [IGN_W-1:0] ignore_q, ignore_d;
  logic             error_q, error_d;

  logic [AW-1:0]    pipe_addr_q [READ_LATENCY];

  logic [ENTRY_W-1:0] mem_q [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               fifo_valid;
  logic               pop;
  logic               credit_ok;
  logic               req;
  logic               ret_live;
  logic               push;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;

  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid && bus.in_force_ready;
  // An entry leaving this cycle frees its slot before the new read can return.
  assign credit_ok  = (count_q + inflight_q) < (DEPTH_C + CNT_W'(pop));
  assign req        = (state_q == S_READ) && credit_ok;

  // Returns arriving right after reset belong to an aborted sweep and are discarded.
  assign ret_live   = bus.in_cache_readout_valid && (ignore_q == '0);
  assign push       = ret_live && (inflight_q != '0);
  assign push_entry = {CX, CY, CZ, pipe_addr_q[READ_LATENCY-1], bus.in_partial_force};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_start) begin
          n_d     = bus.in_particle_num;
          drain_d = DRAIN_ONE;
          state_d = (bus.in_particle_num == '0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q >= DRAIN_LAST) begin
          state_d = S_READ;
          addr_d  = ADDR_ONE;
        end else begin
          drain_d = drain_q + DRAIN_ONE;
        end
      end
      S_READ: begin
        if (req) begin
          if (addr_q == n_q) state_d = S_FLUSH;
          else               addr_d  = addr_q + ADDR_ONE;
        end
      end
      S_FLUSH: begin
        if ((inflight_q == '0) && !fifo_valid) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({req, push})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    ignore_d = (ignore_q != '0) ? ignore_q - IGN_W'(1) : ignore_q;
    error_d  = error_q || (ret_live && (inflight_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      inflight_q <= '0;
      ignore_q   <= IGN_INIT;
      error_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_addr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      inflight_q <= inflight_d;
      ignore_q   <= ignore_d;
      error_q    <= error_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
      pipe_addr_q[0] <= addr_q;
      for (int i = 1; i < READ_LATENCY; i++) pipe_addr_q[i] <= pipe_addr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.out_read_data_request  = req;
  assign bus.out_cache_read_address = req ? addr_q : '0;
  assign bus.out_force_valid        = fifo_valid;
  assign bus.out_particle_id        = fifo_valid ? head[ENTRY_W-1 -: PARTICLE_ID_WIDTH] : '0;
  assign bus.out_force              = fifo_valid ? head[FW-1:0] : '0;
  assign bus.out_busy               = (state_q != S_IDLE);
  assign bus.out_done               = (state_q == S_DONE);
  assign bus.out_error              = error_q;
  assign bus.dbg_state              = state_q;

endmodule
